// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
//
// Writeback stage that sits directly after the 8-bit ALU. Each cycle the ALU
// output is captured into a one-entry stage register. On the following edge
// that entry is committed: the result goes into the general register file,
// the sticky carry/overflow flags merge, and the retired counter advances.
// A taken conditional branch in the stage raises pc_load with its target.
// Two combinational read ports feed operand_a/operand_b back to the ALU.
//
// Optional feature macro: WB_FORWARD_EN
//   When defined, a read that hits the pending (captured, not yet committed)
//   destination returns the pending result. When undefined, reads see the
//   register file only.
//
// Ports:
//   clock               in   system clock, rising edge
//   reset               in   asynchronous active-high reset
//   wb_valid            in   ALU output valid this cycle
//   wb_write_en         in   result is to be written to wb_dest
//   wb_dest             in   destination register
//   wb_is_branch        in   result is a branch condition
//   wb_branch_target    in   PC value if the branch is taken
//   alu_result          in   ALU result
//   shift_overflow      in   ALU shift-out bit
//   arithmetic_overflow in   ALU arithmetic overflow
//   flush               in   squash the entry being captured this cycle
//   flag_clear          in   clear both sticky flags
//   rd_addr_a/b         in   read port addresses
//   rd_data_a/b         out  read port data (combinational)
//   pc_load             out  taken-branch request
//   pc_load_value       out  branch target (0 when pc_load is low)
//   carry_flag          out  sticky shift-overflow flag
//   overflow_flag       out  sticky arithmetic-overflow flag
//   retired_count       out  committed-entry counter, wraps at 256
// -----------------------------------------------------------------------------
module alu_writeback #(
   parameter int DATA_WIDTH = 8,
   parameter int REG_COUNT  = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wb_valid,
   input  logic                  wb_write_en,
   input  logic [ADDR_WIDTH-1:0] wb_dest,
   input  logic                  wb_is_branch,
   input  logic [DATA_WIDTH-1:0] wb_branch_target,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  shift_overflow,
   input  logic                  arithmetic_overflow,
   input  logic                  flush,
   input  logic                  flag_clear,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   output logic                  pc_load,
   output logic [DATA_WIDTH-1:0] pc_load_value,
   output logic                  carry_flag,
   output logic                  overflow_flag,
   output logic [7:0]            retired_count
);

   // Stage register (captured entry awaiting commit)
   logic                  stage_valid_q,     stage_valid_d;
   logic                  stage_write_en_q,  stage_write_en_d;
   logic [ADDR_WIDTH-1:0] stage_dest_q,      stage_dest_d;
   logic                  stage_is_branch_q, stage_is_branch_d;
   logic [DATA_WIDTH-1:0] stage_target_q,    stage_target_d;
   logic [DATA_WIDTH-1:0] stage_result_q,    stage_result_d;
   logic                  stage_shift_ovf_q, stage_shift_ovf_d;
   logic                  stage_arith_ovf_q, stage_arith_ovf_d;

   // Architectural state
   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
   logic                  carry_q,    carry_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            retired_q,  retired_d;

   logic                  commit_write;

   // Capture: every edge, no stall. A flushed entry only needs its valid
   // bit killed; the remaining fields are don't-care but still loaded so the
   // datapath has no extra enable.
   always_comb begin
      stage_valid_d     = wb_valid & ~flush;
      stage_write_en_d  = wb_write_en;
      stage_dest_d      = wb_dest;
      stage_is_branch_d = wb_is_branch;
      stage_target_d    = wb_branch_target;
      stage_result_d    = alu_result;
      stage_shift_ovf_d = shift_overflow;
      stage_arith_ovf_d = arithmetic_overflow;
   end

   // Commit: the staged entry retires regardless of this cycle's flush,
   // which only affects the entry being captured.
   assign commit_write = stage_valid_q & stage_write_en_q & (stage_dest_q != '0);

   always_comb begin
      for (int i = 0; i < REG_COUNT; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (commit_write) begin
         regs_d[stage_dest_q] = stage_result_q;
      end
      // Register 0 is hardwired; writes to it vanish.
      regs_d[0] = '0;
   end

   // Sticky flags: a clear drops the old value, a committing set always
   // wins. With no valid entry, flag_clear simply clears.
   always_comb begin
      carry_d    = (carry_q    & ~flag_clear) | (stage_valid_q & stage_shift_ovf_q);
      overflow_d = (overflow_q & ~flag_clear) | (stage_valid_q & stage_arith_ovf_q);
      retired_d  = retired_q + {7'd0, stage_valid_q};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage_valid_q     <= 1'b0;
         stage_write_en_q  <= 1'b0;
         stage_dest_q      <= '0;
         stage_is_branch_q <= 1'b0;
         stage_target_q    <= '0;
         stage_result_q    <= '0;
         stage_shift_ovf_q <= 1'b0;
         stage_arith_ovf_q <= 1'b0;
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
         carry_q           <= 1'b0;
         overflow_q        <= 1'b0;
         retired_q         <= '0;
      end else begin
         stage_valid_q     <= stage_valid_d;
         stage_write_en_q  <= stage_write_en_d;
         stage_dest_q      <= stage_dest_d;
         stage_is_branch_q <= stage_is_branch_d;
         stage_target_q    <= stage_target_d;
         stage_result_q    <= stage_result_d;
         stage_shift_ovf_q <= stage_shift_ovf_d;
         stage_arith_ovf_q <= stage_arith_ovf_d;
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= regs_d[i];
         end
         carry_q           <= carry_d;
         overflow_q        <= overflow_d;
         retired_q         <= retired_d;
      end
   end

   // Branch request is decoded from registered state only, so it is glitch
   // free relative to the inputs and stays high for exactly the stage cycle.
   always_comb begin
      pc_load       = stage_valid_q & stage_is_branch_q & stage_result_q[0];
      pc_load_value = pc_load ? stage_target_q : '0;
   end

   // Read ports
   function automatic logic [DATA_WIDTH-1:0] read_port(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [DATA_WIDTH-1:0] file_val,
      input logic                  pend_hit,
      input logic [DATA_WIDTH-1:0] pend_val
   );
      logic [DATA_WIDTH-1:0] r;
      r = file_val;
      if (pend_hit) begin
         r = pend_val;
      end
      if (addr == '0) begin
         r = '0;
      end
      return r;
   endfunction

   logic hit_a, hit_b;

`ifdef WB_FORWARD_EN
   // Bypass the pending commit so a dependent op needs no bubble.
   assign hit_a = stage_valid_q & stage_write_en_q & (stage_dest_q == rd_addr_a);
   assign hit_b = stage_valid_q & stage_write_en_q & (stage_dest_q == rd_addr_b);
`else
   // No bypass: the controller inserts a bubble between producer and consumer.
   assign hit_a = 1'b0;
   assign hit_b = 1'b0;
`endif

   assign rd_data_a = read_port(rd_addr_a, regs_q[rd_addr_a], hit_a, stage_result_q);
   assign rd_data_b = read_port(rd_addr_b, regs_q[rd_addr_b], hit_b, stage_result_q);

   assign carry_flag    = carry_q;
   assign overflow_flag = overflow_q;
   assign retired_count = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       wb_valid = 1'b0, wb_write_en = 1'b0, wb_is_branch = 1'b0;
   logic [2:0] wb_dest = '0;
   logic [7:0] wb_branch_target = '0, alu_result = '0;
   logic       shift_overflow = 1'b0, arithmetic_overflow = 1'b0;
   logic       flush = 1'b0, flag_clear = 1'b0;
   logic [2:0] rd_addr_a = '0, rd_addr_b = '0;
   logic [7:0] rd_data_a, rd_data_b, pc_load_value, retired_count;
   logic       pc_load, carry_flag, overflow_flag;

   alu_writeback dut (
      .clock(clock), .reset(reset),
      .wb_valid(wb_valid), .wb_write_en(wb_write_en), .wb_dest(wb_dest),
      .wb_is_branch(wb_is_branch), .wb_branch_target(wb_branch_target),
      .alu_result(alu_result), .shift_overflow(shift_overflow),
      .arithmetic_overflow(arithmetic_overflow), .flush(flush),
      .flag_clear(flag_clear), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .pc_load(pc_load),
      .pc_load_value(pc_load_value), .carry_flag(carry_flag),
      .overflow_flag(overflow_flag), .retired_count(retired_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: an architectural register array, sticky flags, a retire
   // tally and the single instruction in flight between capture and commit.
   typedef struct {
      bit       valid;
      bit       we;
      int       dest;
      bit       br;
      int       tgt;
      int       res;
      bit       sovf;
      bit       aovf;
   } entry_t;

   int     m_regs [8];
   bit     m_carry, m_ovf;
   int     m_retired;
   entry_t m_pend;

   function automatic void model_reset();
      foreach (m_regs[i]) m_regs[i] = 0;
      m_carry = 0; m_ovf = 0; m_retired = 0;
      m_pend = '{default: 0};
   endfunction

   function automatic void model_edge();
      if (m_pend.valid) begin
         if (m_pend.we && m_pend.dest != 0) m_regs[m_pend.dest] = m_pend.res;
         m_carry   = (m_carry && !flag_clear) || m_pend.sovf;
         m_ovf     = (m_ovf && !flag_clear) || m_pend.aovf;
         m_retired = (m_retired + 1) % 256;
      end else if (flag_clear) begin
         m_carry = 0;
         m_ovf   = 0;
      end
      m_pend.valid = wb_valid && !flush;
      m_pend.we    = wb_write_en;
      m_pend.dest  = int'(wb_dest);
      m_pend.br    = wb_is_branch;
      m_pend.tgt   = int'(wb_branch_target);
      m_pend.res   = int'(alu_result);
      m_pend.sovf  = shift_overflow;
      m_pend.aovf  = arithmetic_overflow;
   endfunction

   function automatic int model_read(input int a);
      if (a == 0) return 0;
`ifdef WB_FORWARD_EN
      if (m_pend.valid && m_pend.we && m_pend.dest == a) return m_pend.res;
`endif
      return m_regs[a];
   endfunction

   function automatic bit model_pc_load();
      return m_pend.valid && m_pend.br && (m_pend.res % 2 == 1);
   endfunction

   task automatic check_all(input int a, input int b);
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(b);
      #1;
      check("rd_data_a", rd_data_a, model_read(a));
      check("rd_data_b", rd_data_b, model_read(b));
      check("pc_load", pc_load, model_pc_load());
      check("pc_load_value", pc_load_value, model_pc_load() ? m_pend.tgt : 0);
      check("carry_flag", carry_flag, m_carry);
      check("overflow_flag", overflow_flag, m_ovf);
      check("retired_count", retired_count, m_retired);
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      check_all($urandom_range(0, 7), $urandom_range(0, 7));
   endtask

   task automatic drive(input bit v, input bit we, input int dest, input bit br,
                        input int tgt, input int res, input bit sovf, input bit aovf,
                        input bit fl, input bit fc);
      wb_valid = v; wb_write_en = we; wb_dest = 3'(dest); wb_is_branch = br;
      wb_branch_target = 8'(tgt); alu_result = 8'(res);
      shift_overflow = sovf; arithmetic_overflow = aovf;
      flush = fl; flag_clear = fc;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   int cnt_before;

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state: every address reads zero, outputs idle.
      for (int a = 0; a < 8; a++) check_all(a, 7 - a);

      // Write 0xA5 to r3 and observe the forwarding window.
      drive(1, 1, 3, 0, 0, 8'hA5, 0, 0, 0, 0);
      tick();
      idle();
      rd_addr_a = 3'd3; #1;
`ifdef WB_FORWARD_EN
      check("r3_after_capture", rd_data_a, 8'hA5);
`else
      check("r3_after_capture", rd_data_a, 8'h00);
`endif
      tick();
      rd_addr_a = 3'd3; #1;
      check("r3_after_commit", rd_data_a, 8'hA5);

      // Write to r0 is dropped but still retires.
      drive(1, 1, 0, 0, 0, 8'hFF, 0, 0, 0, 0);
      tick();
      idle();
      tick();
      rd_addr_a = 3'd0; #1;
      check("r0_stays_zero", rd_data_a, 8'h00);
      check("retired_after_r0", retired_count, 8'd2);

      // Set wins over simultaneous clear; clear alone drops the flag.
      drive(1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      tick();
      drive(1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      check("ovf_set_beats_clear", overflow_flag, 1'b1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      check("ovf_cleared", overflow_flag, 1'b0);
      idle();

      // Taken branch, with flush squashing the next entry.
      drive(1, 0, 0, 1, 8'h40, 8'h01, 0, 0, 0, 0);
      tick();
      check("br_pc_load", pc_load, 1'b1);
      check("br_pc_value", pc_load_value, 8'h40);
      cnt_before = int'(retired_count);
      drive(1, 1, 2, 0, 0, 8'h11, 0, 0, 1, 0);
      tick();
      check("br_pc_load_one_cycle", pc_load, 1'b0);
      idle();
      tick();
      rd_addr_a = 3'd2; #1;
      check("r2_unchanged", rd_data_a, 8'h00);
      check("retired_plus_one", retired_count, 8'(cnt_before + 1));
      // Not-taken branch.
      drive(1, 0, 0, 1, 8'h55, 8'h00, 0, 0, 0, 0);
      tick();
      check("br_not_taken", pc_load, 1'b0);
      idle();
      tick();

      // Counter wrap: 256 more commits bring the count back to its start.
      cnt_before = int'(retired_count);
      for (int i = 0; i < 256; i++) begin
         drive(1, 0, 0, 0, 0, $urandom_range(0, 255), 0, 0, 0, 0);
         tick();
      end
      idle();
      tick();
      check("retired_wrap", retired_count, 8'(cnt_before));

      // Randomized traffic; flush is raised when a branch is taken.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 7), $urandom_range(0, 4) == 0,
               $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               model_pc_load() || ($urandom_range(0, 15) == 0),
               $urandom_range(0, 9) == 0);
         tick();
      end

      // Reset mid-stream: outputs drop at once and the pending entry is lost.
      drive(1, 1, 5, 0, 0, 8'h77, 1, 1, 0, 0);
      tick();
      idle();
      reset = 1'b1;
      #1;
      model_reset();
      rd_addr_a = 3'd5; #1;
      check("rst_rd5", rd_data_a, 8'h00);
      check("rst_pc_load", pc_load, 1'b0);
      check("rst_carry", carry_flag, 1'b0);
      check("rst_overflow", overflow_flag, 1'b0);
      check("rst_retired", retired_count, 8'h00);
      reset = 1'b0;
      tick();
      rd_addr_a = 3'd5; #1;
      check("rst_no_commit_r5", rd_data_a, 8'h00);
      check("rst_no_commit_cnt", retired_count, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
